// File: rtl/key_event_uart_if.sv
// key_event_uart_if
// Bundles the keyboard-sniffer inputs and the status/serial outputs of
// key_event_uart.
//   master : the sniffer side; drives modifier/keycode, observes status
//   slave  : key_event_uart itself
// Signals:
//   modifier[7:0]   HID modifier byte (bit1 LShift, bit5 RShift)
//   keycode[7:0]    first HID usage ID, 0x00 = no key
//   uart_tx         8N1 serial out, idle high
//   tx_busy         frame in progress
//   fifo_count      bytes queued, $clog2(FIFO_DEPTH)+1 bits
//   overflow        sticky drop flag
//   event_strobe    one-cycle pulse per accepted press
interface key_event_uart_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    modifier;
    logic [7:0]    keycode;
    logic          uart_tx;
    logic          tx_busy;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          event_strobe;

    modport master (
        output modifier, keycode,
        input  uart_tx, tx_busy, fifo_count, overflow, event_strobe
    );

    modport slave (
        input  modifier, keycode,
        output uart_tx, tx_busy, fifo_count, overflow, event_strobe
    );
endinterface

// File: rtl/key_event_uart.sv
// key_event_uart
// Turns HID key presses from the keyboard sniffer into ASCII and sends them
// out as 8N1 UART, buffered through a small byte FIFO.
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   key_event_uart_if.slave (modifier, keycode in; uart_tx, tx_busy,
//         fifo_count, overflow, event_strobe out)
// Parameters: CLK_HZ, BAUD (bit period = CLK_HZ/BAUD cycles), FIFO_DEPTH
// (power of two, >= 4).
// Build option: define CRLF_EN to make Enter (0x28) emit 0x0D 0x0A instead
// of 0x0D alone.
//
// TX FSM
//   state   | meaning
//   S_IDLE  | line high, waiting for a queued byte
//   S_START | start bit (0)
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit (1); chains straight into S_START if more is queued
module key_event_uart #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    key_event_uart_if.slave bus
);
    localparam int DIVISOR = CLK_HZ / BAUD;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int BW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIVISOR - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    // ------------------------------------------------------------------
    // Input stage and event detection
    // ------------------------------------------------------------------
    logic [7:0] kc_q;
    logic [7:0] mod_q;
    logic [7:0] prev_kc;
    logic       ev_det;
    logic       shift;
    logic [7:0] ascii;

    always_ff @(posedge clk) begin
        if (rst) begin
            kc_q    <= 8'h00;
            mod_q   <= 8'h00;
            prev_kc <= 8'h00;
        end else begin
            kc_q    <= bus.keycode;
            mod_q   <= bus.modifier;
            prev_kc <= kc_q;
        end
    end

    // 0x01..0x03 are rollover/error codes, 0x39 is Caps Lock.
    assign ev_det = (kc_q != prev_kc) && (kc_q >= 8'h04) && (kc_q != 8'h39);

    always_comb begin
        shift = mod_q[1] | mod_q[5];
        ascii = 8'h3F;
        if (kc_q >= 8'h04 && kc_q <= 8'h1D) begin
            ascii = (shift ? 8'h41 : 8'h61) + (kc_q - 8'h04);
        end else if (kc_q >= 8'h1E && kc_q <= 8'h26) begin
            ascii = 8'h31 + (kc_q - 8'h1E);
        end else begin
            case (kc_q)
                8'h27:   ascii = 8'h30;
                8'h28:   ascii = 8'h0D;
                8'h2A:   ascii = 8'h08;
                8'h2B:   ascii = 8'h09;
                8'h2C:   ascii = 8'h20;
                default: ascii = 8'h3F;
            endcase
        end
    end

    logic       ev_q;
    logic [7:0] ev_byte;
`ifdef CRLF_EN
    logic       ev_cr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_q    <= 1'b0;
            ev_byte <= 8'h00;
`ifdef CRLF_EN
            ev_cr   <= 1'b0;
`endif
        end else begin
            ev_q    <= ev_det;
            ev_byte <= ascii;
`ifdef CRLF_EN
            ev_cr   <= (kc_q == 8'h28);
`endif
        end
    end

    // ------------------------------------------------------------------
    // FIFO write selection
    // ------------------------------------------------------------------
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          overflow_q;
    logic          pop;
    logic          push;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          space_ok;
    logic          ovf_set;

`ifdef CRLF_EN
    // lf_pend: the 0x0A half of a CR/LF pair goes in this cycle; its slot
    // was reserved when the 0x0D was accepted. An event landing in that
    // cycle parks in the held register for one cycle.
    logic          lf_pend;
    logic          held_v;
    logic [7:0]    held_byte;
    logic          held_cr;
    logic          wr_pair;
    logic          hold_new;
    logic          drop_new;
    logic [CW:0]   free_slots;

    always_comb begin
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        wr_pair  = 1'b0;
        hold_new = 1'b0;
        drop_new = 1'b0;
        if (lf_pend) begin
            wr_en   = 1'b1;
            wr_data = 8'h0A;
            if (ev_q) begin
                if (held_v) drop_new = 1'b1;
                else        hold_new = 1'b1;
            end
        end else if (held_v) begin
            wr_en   = 1'b1;
            wr_data = held_byte;
            wr_pair = held_cr;
            if (ev_q) hold_new = 1'b1;
        end else if (ev_q) begin
            wr_en   = 1'b1;
            wr_data = ev_byte;
            wr_pair = ev_cr;
        end
    end

    assign free_slots = {1'b0, DEPTH_C} - {1'b0, count} + {{CW{1'b0}}, pop};
    assign space_ok   = wr_pair ? (free_slots >= (CW+1)'(2))
                                : (free_slots >= (CW+1)'(1));
    assign push       = wr_en && space_ok;
    assign ovf_set    = (wr_en && !space_ok) || drop_new;

    always_ff @(posedge clk) begin
        if (rst) begin
            lf_pend   <= 1'b0;
            held_v    <= 1'b0;
            held_byte <= 8'h00;
            held_cr   <= 1'b0;
        end else begin
            lf_pend <= push && wr_pair;
            if (hold_new) begin
                held_v    <= 1'b1;
                held_byte <= ev_byte;
                held_cr   <= ev_cr;
            end else if (!lf_pend && held_v) begin
                held_v <= 1'b0;
            end
        end
    end
`else
    assign wr_en    = ev_q;
    assign wr_data  = ev_byte;
    assign space_ok = (count < DEPTH_C) || pop;
    assign push     = wr_en && space_ok;
    assign ovf_set  = wr_en && !space_ok;
`endif

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [7:0] mem [FIFO_DEPTH];
    logic [7:0] rd_data;
    logic       fifo_ne;

    assign fifo_ne = (count != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf_set) overflow_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t     state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          tx_q;
    logic          busy_q;
    logic          baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign pop      = fifo_ne && ((state == S_IDLE) || (state == S_STOP && baud_end));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fifo_ne) begin
                        shreg    <= rd_data;
                        baud_cnt <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= 3'd0;
                        tx_q     <= shreg[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_q    <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (fifo_ne) begin
                            // same-cycle pop keeps frames back-to-back
                            shreg <= rd_data;
                            tx_q  <= 1'b0;
                            state <= S_START;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.uart_tx      = tx_q;
    assign bus.tx_busy      = busy_q;
    assign bus.fifo_count   = count;
    assign bus.overflow     = overflow_q;
    assign bus.event_strobe = ev_q;
endmodule

// File: tb/tb_key_event_uart.sv
// tb_key_event_uart
// Drives key sequences into key_event_uart, decodes uart_tx with a bit-level
// receiver and compares the byte stream, event pulses and status flags
// against a reference model of the key-to-ASCII rules.
// The DUT runs with a 10 MHz CLK_HZ so a bit is 86 cycles and long frame
// trains stay short in simulation time.
module tb_key_event_uart;
    localparam int TB_CLK_HZ = 10000000;
    localparam int TB_BAUD   = 115200;
    localparam int DIV       = TB_CLK_HZ / TB_BAUD;
    localparam int DEPTH     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    key_event_uart_if #(.FIFO_DEPTH(DEPTH)) ifc ();

    key_event_uart #(
        .CLK_HZ(TB_CLK_HZ),
        .BAUD(TB_BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- receiver and observers ----------------
    logic [7:0] rxq [$];
    int         gapq [$];
    int         frame_err = 0;
    int         strobe_cnt = 0;
    int         peak = 0;
    int         last_end = -100000;

    always @(negedge clk) begin
        if (ifc.event_strobe === 1'b1) strobe_cnt++;
        if (int'(ifc.fifo_count) > peak) peak = int'(ifc.fifo_count);
    end

    initial begin : rx_mon
        logic [9:0] bits;
        logic       aborted;
        int         start_cyc;
        forever begin
            @(negedge clk);
            if (!rst && ifc.uart_tx === 1'b0) begin
                start_cyc = cyc;
                aborted   = 1'b0;
                bits      = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < DIV && !aborted; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (rst) aborted = 1'b1;
                        else if (c == 0) bits[b] = ifc.uart_tx;
                        else if (ifc.uart_tx !== bits[b]) frame_err++;
                    end
                end
                if (!aborted) begin
                    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) frame_err++;
                    rxq.push_back(bits[8:1]);
                    gapq.push_back(start_cyc - last_end - 1);
                    last_end = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_ascii(input logic [7:0] kc, input logic [7:0] mod);
        int  k;
        bit  sh;
        k  = int'(kc);
        sh = mod[1] || mod[5];
        if (k >= 4 && k <= 29) return 8'((sh ? 65 : 97) + k - 4);
        if (k >= 30 && k <= 38) return 8'(49 + k - 30);
        if (k == 39) return 8'd48;
        if (k == 40) return 8'd13;
        if (k == 42) return 8'd8;
        if (k == 43) return 8'd9;
        if (k == 44) return 8'd32;
        return 8'd63;
    endfunction

    function automatic bit model_event(input logic [7:0] kc, input logic [7:0] prev);
        return (kc != prev) && (int'(kc) >= 4) && (kc != 8'h39);
    endfunction

    task automatic model_push(inout logic [7:0] q [$], input logic [7:0] kc, input logic [7:0] mod);
        q.push_back(model_ascii(kc, mod));
`ifdef CRLF_EN
        if (kc == 8'h28) q.push_back(8'h0A);
`endif
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_key(input logic [7:0] kc, input logic [7:0] mod);
        @(posedge clk);
        #1;
        ifc.keycode  = kc;
        ifc.modifier = mod;
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        int run;
        ok  = 1'b0;
        run = 0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (ifc.tx_busy === 1'b0 && ifc.fifo_count == 0 && ifc.uart_tx === 1'b1) run++;
            else run = 0;
            if (run >= 3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        ifc.keycode  = 8'h00;
        ifc.modifier = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++; if (ifc.uart_tx !== 1'b1) begin bad++; $display("FAIL reset_uart_tx: got %b want 1", ifc.uart_tx); end
        total++; if (ifc.tx_busy !== 1'b0) begin bad++; $display("FAIL reset_tx_busy: got %b want 0", ifc.tx_busy); end
        total++; if (ifc.fifo_count !== 5'd0) begin bad++; $display("FAIL reset_fifo_count: got %0d want 0", ifc.fifo_count); end
        total++; if (ifc.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", ifc.overflow); end
        total++; if (ifc.event_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", ifc.event_strobe); end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_single_press();
        int s0, e0;
        bit ok;
        rxq.delete(); gapq.delete();
        s0 = strobe_cnt; e0 = frame_err;
        set_key(8'h04, 8'h00);
        @(posedge clk);             // edge N: keycode registered
        @(negedge clk);
        total++; if (ifc.event_strobe !== 1'b0) begin bad++; $display("FAIL lat_strobe_n: got %b want 0", ifc.event_strobe); end
        @(negedge clk);             // after N+1
        total++; if (ifc.event_strobe !== 1'b1) begin bad++; $display("FAIL lat_strobe_n1: got %b want 1", ifc.event_strobe); end
        @(negedge clk);             // after N+2: byte written
        total++; if (ifc.event_strobe !== 1'b0) begin bad++; $display("FAIL lat_strobe_n2: got %b want 0", ifc.event_strobe); end
        total++; if (ifc.fifo_count !== 5'd1) begin bad++; $display("FAIL lat_fifo_write: got %0d want 1", ifc.fifo_count); end
        @(negedge clk);             // after N+3: popped
        @(negedge clk);
        total++; if (ifc.uart_tx !== 1'b0) begin bad++; $display("FAIL start_bit_latency: got %b want 0", ifc.uart_tx); end
        total++; if (ifc.tx_busy !== 1'b1) begin bad++; $display("FAIL busy_in_frame: got %b want 1", ifc.tx_busy); end
        wait_idle(3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout: got busy want idle"); end
        total++; if (rxq.size() != 1) begin bad++; $display("FAIL single_count: got %0d want 1", rxq.size()); end
        else begin
            total++; if (rxq[0] !== 8'h61) begin bad++; $display("FAIL single_byte: got %02h want 61", rxq[0]); end
        end
        total++; if (strobe_cnt - s0 != 1) begin bad++; $display("FAIL single_strobe: got %0d want 1", strobe_cnt - s0); end
        total++; if (frame_err != e0) begin bad++; $display("FAIL single_framing: got %0d errors want 0", frame_err - e0); end
    endtask

    task automatic test_held_shift();
        int s0;
        bit ok;
        set_key(8'h00, 8'h00);
        repeat (5) @(posedge clk);
        rxq.delete(); gapq.delete();
        s0 = strobe_cnt;
        set_key(8'h04, 8'h02);
        repeat (10000) @(posedge clk);
        wait_idle(3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL held_timeout: got busy want idle"); end
        total++; if (rxq.size() != 1) begin bad++; $display("FAIL held_count: got %0d want 1", rxq.size()); end
        else begin
            total++; if (rxq[0] !== 8'h41) begin bad++; $display("FAIL held_byte: got %02h want 41", rxq[0]); end
        end
        total++; if (strobe_cnt - s0 != 1) begin bad++; $display("FAIL held_strobe: got %0d want 1", strobe_cnt - s0); end
        total++; if (ifc.fifo_count !== 5'd0) begin bad++; $display("FAIL held_fifo_empty: got %0d want 0", ifc.fifo_count); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        set_key(8'h00, 8'h00);
        repeat (5) @(posedge clk);
        rxq.delete(); gapq.delete();
        set_key(8'h04, 8'h00);
        repeat (5) @(posedge clk);
        set_key(8'h05, 8'h00);
        wait_idle(5000, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got busy want idle"); end
        total++; if (rxq.size() != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", rxq.size()); end
        else begin
            total++; if (rxq[0] !== 8'h61) begin bad++; $display("FAIL b2b_byte0: got %02h want 61", rxq[0]); end
            total++; if (rxq[1] !== 8'h62) begin bad++; $display("FAIL b2b_byte1: got %02h want 62", rxq[1]); end
            total++; if (gapq[1] != 0) begin bad++; $display("FAIL b2b_gap: got %0d idle cycles want 0", gapq[1]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp [$];
        logic [7:0] prev, kc, mod;
        bit ok;
        set_key(8'h00, 8'h00);
        repeat (5) @(posedge clk);
        rxq.delete(); gapq.delete();
        prev = 8'h00;
        for (int i = 0; i < 20; i++) begin
            do kc = 8'($urandom_range(4, 29)); while (kc == prev);
            mod = 8'($urandom_range(0, 255));
            model_push(exp, kc, mod);
            prev = kc;
            set_key(kc, mod);
            repeat (7) @(posedge clk);
        end
        @(negedge clk);
        total++; if (ifc.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", ifc.overflow); end
        total++; if (peak != DEPTH) begin bad++; $display("FAIL ovf_peak: got %0d want %0d", peak, DEPTH); end
        wait_idle(20000, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_timeout: got busy want idle"); end
        total++; if (rxq.size() != DEPTH + 1) begin bad++; $display("FAIL ovf_count: got %0d want %0d", rxq.size(), DEPTH + 1); end
        else begin
            for (int i = 0; i <= DEPTH; i++) begin
                total++; if (rxq[i] !== exp[i]) begin bad++; $display("FAIL ovf_byte%0d: got %02h want %02h", i, rxq[i], exp[i]); end
            end
        end
        total++; if (ifc.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ifc.overflow); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok, seen;
        logic [7:0] mod;
        set_key(8'h00, 8'h00);
        repeat (5) @(posedge clk);
        set_key(8'h07, 8'h00);
        repeat (3) @(posedge clk);
        set_key(8'h08, 8'h00);
        repeat (3) @(posedge clk);
        set_key(8'h09, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ifc.uart_tx === 1'b0) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL rstmid_no_start: got idle line want start bit"); end
        repeat (4 * DIV + DIV / 2) @(negedge clk);
        total++; if (ifc.tx_busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", ifc.tx_busy); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        ifc.keycode = 8'h00;
        @(posedge clk);
        @(negedge clk);
        total++; if (ifc.uart_tx !== 1'b1) begin bad++; $display("FAIL rstmid_uart_tx: got %b want 1", ifc.uart_tx); end
        total++; if (ifc.tx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", ifc.tx_busy); end
        total++; if (ifc.fifo_count !== 5'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", ifc.fifo_count); end
        total++; if (ifc.overflow !== 1'b0) begin bad++; $display("FAIL rstmid_overflow: got %b want 0", ifc.overflow); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        rxq.delete(); gapq.delete();
        mod = 8'($urandom_range(0, 255));
        set_key(8'h1E, mod);
        wait_idle(3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout: got busy want idle"); end
        total++; if (rxq.size() != 1) begin bad++; $display("FAIL rstmid_post_count: got %0d want 1", rxq.size()); end
        else begin
            total++; if (rxq[0] !== 8'h31) begin bad++; $display("FAIL rstmid_post_byte: got %02h want 31", rxq[0]); end
        end
    endtask

    task automatic test_special_codes();
        logic [7:0] seq [7];
        logic [7:0] exp [$];
        logic [7:0] prev;
        int s0, nev;
        bit ok;
        seq = '{8'h00, 8'h28, 8'h00, 8'h02, 8'h00, 8'h39, 8'h00};
        set_key(8'h00, 8'h00);
        repeat (5) @(posedge clk);
        rxq.delete(); gapq.delete();
        s0 = strobe_cnt;
        prev = 8'h00;
        nev = 0;
        foreach (seq[i]) begin
            if (model_event(seq[i], prev)) begin
                nev++;
                model_push(exp, seq[i], 8'h00);
            end
            prev = seq[i];
            set_key(seq[i], 8'h00);
            repeat (20) @(posedge clk);
        end
        wait_idle(5000, ok);
        total++; if (!ok) begin bad++; $display("FAIL special_timeout: got busy want idle"); end
        total++; if (strobe_cnt - s0 != nev) begin bad++; $display("FAIL special_strobe: got %0d want %0d", strobe_cnt - s0, nev); end
        total++; if (rxq.size() != exp.size()) begin bad++; $display("FAIL special_count: got %0d want %0d", rxq.size(), exp.size()); end
        else begin
            foreach (exp[i]) begin
                total++; if (rxq[i] !== exp[i]) begin bad++; $display("FAIL special_byte%0d: got %02h want %02h", i, rxq[i], exp[i]); end
            end
        end
    endtask

    task automatic test_random_keys();
        logic [7:0] exp [$];
        logic [7:0] prev, kc, mod;
        int s0, nev;
        bit ok;
        set_key(8'h00, 8'h00);
        repeat (5) @(posedge clk);
        rxq.delete(); gapq.delete();
        s0 = strobe_cnt;
        prev = 8'h00;
        nev = 0;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 5))
                0:       kc = 8'h00;
                1:       kc = 8'($urandom_range(1, 3));
                2:       kc = 8'h39;
                3:       kc = 8'($urandom_range(4, 29));
                4:       kc = 8'($urandom_range(30, 44));
                default: kc = 8'($urandom_range(0, 100));
            endcase
            mod = 8'($urandom_range(0, 255));
            if (model_event(kc, prev)) begin
                nev++;
                model_push(exp, kc, mod);
            end
            prev = kc;
            set_key(kc, mod);
            repeat (20 + $urandom_range(0, 20)) @(posedge clk);
        end
        wait_idle(20000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rand_timeout: got busy want idle"); end
        total++; if (strobe_cnt - s0 != nev) begin bad++; $display("FAIL rand_strobe: got %0d want %0d", strobe_cnt - s0, nev); end
        total++; if (rxq.size() != exp.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", rxq.size(), exp.size()); end
        else begin
            foreach (exp[i]) begin
                total++; if (rxq[i] !== exp[i]) begin bad++; $display("FAIL rand_byte%0d: got %02h want %02h", i, rxq[i], exp[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_held_shift();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_special_codes();
        test_random_keys();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
